// File: rtl/sigmoid_pkg.sv
// Shared widths, output-max helper and stage-1 record for the sigmoid LUT pipeline.
package sigmoid_pkg;

    localparam int IN_W_D  = 7;
    localparam int OUT_W_D = 7;
    localparam int CNT_W_D = 16;

    function automatic int unsigned OUT_MAX(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Stage-1 record; idx is sized for the default input width, which the top's IN_W must match.
    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [IN_W_D-1:0] idx;
    } s1_rec_t;

endpackage

// File: rtl/sigmoid_lut_tbl.sv
// Flop lookup table: synchronous write, asynchronous read, write-first forwarding on same-address collision.
module sigmoid_lut_tbl #(
    parameter int AW = 7,
    parameter int DW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];

    // Table storage, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port; a same-cycle write to the read address wins
    always_comb begin
        rdata = mem_q[raddr];
        if (we && (waddr == raddr)) begin
            rdata = wdata;
        end else begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/sigmoid_lut_pipe.sv
// Programmable sigmoid LUT with a 2-stage valid/ready pipeline and saturating lookup counter.
// Optional SIGMOID_LUT_SYMM_EN: signed input, half-depth table, negative side via 1 - sigmoid(|x|).
module sigmoid_lut_pipe
    import sigmoid_pkg::*;
#(
    parameter int IN_W  = IN_W_D,
    parameter int OUT_W = OUT_W_D,
    parameter int CNT_W = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tbl_we,
    input  logic [IN_W-1:0]  tbl_addr,
    input  logic [OUT_W-1:0] tbl_wdata,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] lookup_cnt
);

`ifdef SIGMOID_LUT_SYMM_EN
    localparam int TBL_AW = IN_W - 1;
`else
    localparam int TBL_AW = IN_W;
`endif
    localparam logic [OUT_W-1:0] OUT_ALL = OUT_W'(OUT_MAX(OUT_W));
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    s1_rec_t            s1_q, s1_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               adv_s;
    logic               tbl_we_s;
    logic [TBL_AW-1:0]  tbl_waddr_s;
    logic [TBL_AW-1:0]  tbl_raddr_s;
    logic [OUT_W-1:0]   tbl_rdata_s;
    logic [IN_W-1:0]    mag_s;
    logic               sign_s;

    assign adv_s = !out_valid_q || out_ready;

    // Table addressing and stage-1 index/sign derivation
    always_comb begin
`ifdef SIGMOID_LUT_SYMM_EN
        tbl_we_s    = tbl_we && !tbl_addr[IN_W-1];
        tbl_waddr_s = tbl_addr[TBL_AW-1:0];
        sign_s      = in_data[IN_W-1];
        if (in_data[IN_W-1]) begin
            mag_s = (~in_data) + IN_W'(1);
        end else begin
            mag_s = in_data;
        end
        // Magnitude of the most negative code has only its top bit set; clamp it to the last entry.
        if (s1_q.idx[IN_W-1]) begin
            tbl_raddr_s = {TBL_AW{1'b1}};
        end else begin
            tbl_raddr_s = s1_q.idx[TBL_AW-1:0];
        end
`else
        tbl_we_s    = tbl_we;
        tbl_waddr_s = tbl_addr;
        sign_s      = 1'b0;
        mag_s       = in_data;
        tbl_raddr_s = TBL_AW'(s1_q.idx);
`endif
    end

    sigmoid_lut_tbl #(
        .AW (TBL_AW),
        .DW (OUT_W)
    ) u_tbl (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we_s),
        .waddr (tbl_waddr_s),
        .wdata (tbl_wdata),
        .raddr (tbl_raddr_s),
        .rdata (tbl_rdata_s)
    );

    // Pipeline advance and saturating lookup counter
    always_comb begin
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;
        if (adv_s) begin
            s1_d.valid  = in_valid;
            s1_d.sign   = sign_s;
            s1_d.idx    = IN_W_D'(mag_s);
            out_valid_d = s1_q.valid;
            if (s1_q.valid) begin
                out_data_d = s1_q.sign ? (OUT_ALL - tbl_rdata_s) : tbl_rdata_s;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            s1_d        = s1_q;
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
        if (out_valid_q && out_ready && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = adv_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign lookup_cnt = cnt_q;

endmodule

// File: tb/tb_sigmoid_lut_pipe.sv
// Randomised self-checking bench for sigmoid_lut_pipe against a transaction-level table/queue model.
module tb_sigmoid_lut_pipe;

    localparam int CNT_W   = 4;
    localparam int CNT_TOP = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tbl_we = 1'b0;
    logic [6:0]       tbl_addr = 7'h00;
    logic [6:0]       tbl_wdata = 7'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_data = 7'h00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [6:0]       out_data;
    logic [CNT_W-1:0] lookup_cnt;

    sigmoid_lut_pipe #(.IN_W(7), .OUT_W(7), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .lookup_cnt (lookup_cnt)
    );

    always #5 clk = ~clk;

    int chk = 0;
    int pass = 0;

    // reference model: table contents, items waiting for lookup, visible output, counter
    logic [6:0] m_tbl [128];
    int         m_pend [$];
    logic       m_valid;
    logic [6:0] m_data;
    int         m_cnt;
    logic       exp_rdy, obs_rdy;
    int         n_acc, n_obs;
    logic [6:0] got [$];

    function automatic logic [6:0] m_lookup(int x);
`ifdef SIGMOID_LUT_SYMM_EN
        int mag;
        if (x < 64) return m_tbl[x];
        mag = 128 - x;
        if (mag > 63) mag = 63;
        return 7'h7F - m_tbl[mag];
`else
        return m_tbl[x];
`endif
    endfunction

    function automatic logic [12:0] dut_vec();
        return {obs_rdy, out_valid, out_data, lookup_cnt};
    endfunction

    function automatic logic [12:0] exp_vec();
        return {exp_rdy, m_valid, m_data, 4'(m_cnt)};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 128; i++) m_tbl[i] = 7'h00;
        m_pend.delete();
        m_valid = 1'b0;
        m_data  = 7'h00;
        m_cnt   = 0;
    endtask

    // one clock: drive at negedge, predict, advance to next negedge
    task automatic cyc(input bit we, input int wa, input int wd, input bit iv, input int id, input bit ordy);
        bit adv;
        tbl_we = we; tbl_addr = 7'(wa); tbl_wdata = 7'(wd);
        in_valid = iv; in_data = 7'(id); out_ready = ordy;
        #1;
        obs_rdy = in_ready;
        if (out_valid && ordy) n_obs++;
        adv = !m_valid || ordy;
        exp_rdy = adv;
        if (m_valid && ordy && m_cnt < CNT_TOP) m_cnt++;
`ifdef SIGMOID_LUT_SYMM_EN
        if (we && wa < 64) m_tbl[wa] = 7'(wd);
`else
        if (we) m_tbl[wa] = 7'(wd);
`endif
        if (adv) begin
            if (m_pend.size() > 0) begin
                m_data  = m_lookup(m_pend.pop_front());
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (iv) begin
                m_pend.push_back(id & 127);
                n_acc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        tbl_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk++;
        if ({in_ready, out_valid, out_data, lookup_cnt} !== {1'b1, 1'b0, 7'h00, 4'h0}) begin
            $display("FAIL reset got rdy=%b v=%b d=%h cnt=%0d want rdy=1 v=0 d=00 cnt=0", in_ready, out_valid, out_data, lookup_cnt);
        end else pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_first();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, i == 0, 'h3E, 1);
            chk++;
            if (dut_vec() !== exp_vec()) $display("FAIL first[%0d] got %h want %h", i, dut_vec(), exp_vec());
            else pass++;
            if (i == 1) begin
                chk++;
                if ({out_valid, out_data} !== {1'b1, 7'h00}) $display("FAIL first_latency got v=%b d=%h want v=1 d=00", out_valid, out_data);
                else pass++;
            end
        end
        chk++;
        if (lookup_cnt !== 4'd1) $display("FAIL first_cnt got %0d want 1", lookup_cnt);
        else pass++;
    endtask

    task automatic test_back_to_back();
        int wa [3] = '{'h72, 'h6E, 'h65};
        int wd [3] = '{'h0B, 'h0C, 'h0F};
        got.delete();
        for (int i = 0; i < 3; i++) cyc(1, wa[i], wd[i], 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, i < 3, wa[i % 3], 1);
            if (out_valid) got.push_back(out_data);
            chk++;
            if (dut_vec() !== exp_vec()) $display("FAIL b2b[%0d] got %h want %h", i, dut_vec(), exp_vec());
            else pass++;
        end
`ifndef SIGMOID_LUT_SYMM_EN
        chk++;
        if (got.size() != 3 || got[0] !== 7'h0B || got[1] !== 7'h0C || got[2] !== 7'h0F)
            $display("FAIL b2b_seq got n=%0d want 0b,0c,0f in 3 outputs", got.size());
        else pass++;
`endif
    endtask

    task automatic test_collision();
        cyc(0, 0, 0, 1, 'h55, 1);
        cyc(1, 'h55, 'h0E, 0, 0, 1);
        chk++;
        if (dut_vec() !== exp_vec()) $display("FAIL collision got %h want %h", dut_vec(), exp_vec());
        else pass++;
`ifndef SIGMOID_LUT_SYMM_EN
        chk++;
        if ({out_valid, out_data} !== {1'b1, 7'h0E}) $display("FAIL collision_fwd got v=%b d=%h want v=1 d=0e", out_valid, out_data);
        else pass++;
`endif
    endtask

    task automatic test_stall();
        logic [6:0] ids [8];
        int  k = 0;
        bit  ordy, acc;
        for (int i = 0; i < 32; i++) cyc(1, $urandom_range(0, 127), $urandom_range(0, 127), 0, 0, 1);
        for (int i = 0; i < 8; i++) ids[i] = 7'($urandom_range(0, 127));
        n_acc = 0; n_obs = 0;
        for (int c = 0; c < 20; c++) begin
            ordy = !(c >= 4 && c < 8);
            acc  = !m_valid || ordy;
            cyc(0, 0, 0, k < 8, ids[k % 8], ordy);
            if (acc && k < 8) k++;
            chk++;
            if (dut_vec() !== exp_vec()) $display("FAIL stall[%0d] got %h want %h", c, dut_vec(), exp_vec());
            else pass++;
        end
        chk++;
        if (n_obs != 8 || n_acc != 8) $display("FAIL stall_count got out=%0d in=%0d want 8 and 8", n_obs, n_acc);
        else pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 127), $urandom_range(0, 127),
                $urandom_range(0, 3) != 0, $urandom_range(0, 127), $urandom_range(0, 9) < 7);
            chk++;
            if (dut_vec() !== exp_vec()) $display("FAIL random[%0d] got %h want %h", c, dut_vec(), exp_vec());
            else pass++;
        end
    endtask

    task automatic test_counter_and_reset();
        apply_reset();
        for (int i = 0; i < 22; i++) begin
            cyc(0, 0, 0, i < 20, $urandom_range(0, 127), 1);
            chk++;
            if (dut_vec() !== exp_vec()) $display("FAIL cnt[%0d] got %h want %h", i, dut_vec(), exp_vec());
            else pass++;
        end
        chk++;
        if (lookup_cnt !== 4'd15) $display("FAIL cnt_sat got %0d want 15", lookup_cnt);
        else pass++;
        for (int i = 0; i < 3; i++) cyc(1, i, 'h33, 1, i, 1);
        rst_n = 1'b0;
        #1;
        chk++;
        if ({out_valid, out_data, lookup_cnt} !== {1'b0, 7'h00, 4'h0})
            $display("FAIL midreset got v=%b d=%h cnt=%0d want v=0 d=00 cnt=0", out_valid, out_data, lookup_cnt);
        else pass++;
        m_reset();
        tbl_we = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, i == 0, 1, 1);
            chk++;
            if (dut_vec() !== exp_vec()) $display("FAIL after_reset[%0d] got %h want %h", i, dut_vec(), exp_vec());
            else pass++;
            if (i == 1) begin
                chk++;
                if ({out_valid, out_data} !== {1'b1, 7'h00}) $display("FAIL after_reset_lat got v=%b d=%h want v=1 d=00", out_valid, out_data);
                else pass++;
            end
        end
    endtask

`ifdef SIGMOID_LUT_SYMM_EN
    task automatic test_symm();
        int xs [3] = '{'h05, 'h7B, 'h40};
        apply_reset();
        got.delete();
        cyc(1, 5, 'h50, 0, 0, 1);
        cyc(1, 63, 'h7F, 0, 0, 1);
        cyc(1, 'h7B, 'h11, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, i < 3, xs[i % 3], 1);
            if (out_valid) got.push_back(out_data);
            chk++;
            if (dut_vec() !== exp_vec()) $display("FAIL symm[%0d] got %h want %h", i, dut_vec(), exp_vec());
            else pass++;
        end
        chk++;
        if (got.size() != 3 || got[0] !== 7'h50 || got[1] !== 7'h2F || got[2] !== 7'h00)
            $display("FAIL symm_seq got n=%0d want 50,2f,00 in 3 outputs", got.size());
        else pass++;
    endtask
`endif

    initial begin
        n_acc = 0; n_obs = 0;
        test_reset();
        test_first();
        test_back_to_back();
        test_collision();
        test_stall();
        test_random();
        test_counter_and_reset();
`ifdef SIGMOID_LUT_SYMM_EN
        test_symm();
`endif
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/sigmoid_lut_pipe.md
Name: sigmoid_lut_pipe

Overview:
- Parametrised, programmable sigmoid activation engine for the CNN layer datapath.
- Replaces fixed per-layer hard-wired sigmoid tables with a single block. The table is loaded at run time through a write port.
- Streams activations through a 2-stage valid/ready pipeline.
- One instance per layer output stream, placed between the accumulator/quantiser and the next layer's input buffer.

Parameters:
- IN_W, 7, input code width; table depth = 2**IN_W.
- OUT_W, 7, output code width.
- CNT_W, 16, width of the lookup counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tbl_we  input  1  table write strobe.
- tbl_addr  input  IN_W  table write address.
- tbl_wdata  input  OUT_W  table write data.
- in_valid  input  1  input code valid.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  IN_W  input code.
- out_valid  output  1  output valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  OUT_W  sigmoid result.
- lookup_cnt  output  CNT_W  completed lookups, saturating.

Behaviour:
- Reset (async assert, sync deassert at the consumer):
  - all table entries = 0
  - stage-1 and stage-2 valid = 0
  - out_valid = 0, out_data = 0, lookup_cnt = 0
  - in_ready = 1 after reset, because the pipe is empty.
- Table:
  - Flop array, 2**IN_W x OUT_W.
  - tbl_we=1 writes tbl_wdata to tbl_addr at the clock edge.
  - Writes are always accepted, independent of the handshake.
- Pipeline:
  - Global enable adv = !out_valid || out_ready.
  - in_ready = adv.
  - Stage 1 registers the index and a valid bit when in_valid && in_ready.
  - Stage 2 reads the table at the stage-1 index when adv, and registers out_data and out_valid.
- Latency and throughput:
  - Latency is exactly 2 cycles from input acceptance to out_valid, with out_ready held high.
  - Throughput is 1 per cycle.
- Stall:
  - out_valid && !out_ready freezes both stages.
  - out_data and out_valid stay stable.
  - in_ready = 0.
- Bubbles: a stage-1 bubble (valid=0) advances as a bubble. out_data holds its last value when out_valid=0.
- Write/read collision: tbl_we in the same cycle stage 2 reads the same address forwards tbl_wdata (write-first). Different addresses do not interact.
- Mid-stream writes: the value produced is the table content at the stage-1-to-stage-2 transfer cycle. There is no snapshot at input acceptance.
- lookup_cnt:
  - Increments on out_valid && out_ready.
  - Saturates at 2**CNT_W-1, with no wrap.
- Reset mid-operation: all in-flight items are discarded immediately, and the table is cleared. The next accepted input produces output after 2 cycles.

Optional Feature:
- Macro SIGMOID_LUT_SYMM_EN.
- Defined:
  - in_data and tbl_addr are two's complement.
  - The table holds only the non-negative half: depth 2**(IN_W-1), indexed by the magnitude.
  - Writes with a negative tbl_addr are ignored.
  - For negative x: out_data = (2**OUT_W-1) - table[|x|], using sigmoid(-x)=1-sigmoid(x). Magnitude -2**(IN_W-1) clamps to index 2**(IN_W-1)-1.
  - The sign bit travels with stage 1; the subtraction happens in stage 2, so latency is unchanged.
- Undefined: unsigned full-depth table as described above.

Decomposition:
- Package sigmoid_pkg holds:
  - default widths IN_W_D=7, OUT_W_D=7, CNT_W_D=16
  - OUT_MAX function (2**w-1)
  - a typedef for the stage-1 record {valid, sign, idx}.
- One sub-module, sigmoid_lut_tbl: flop table with write port, async-read port, and write-first forwarding. It is reused by other activation blocks.

Test Plan:
- Reset then stream input 0x3E with out_ready=1 -> out_valid at cycle +2 with out_data 0x00. All table reads return 0 before loading; lookup_cnt=1.
- Load table[0x72]=0x0B, [0x6E]=0x0C, [0x65]=0x0F, then stream 0x72,0x6E,0x65 back-to-back -> outputs 0x0B,0x0C,0x0F on 3 consecutive cycles, in_ready constantly 1.
- Stall: hold out_ready=0 for 4 cycles mid-stream -> out_data/out_valid frozen, in_ready=0, no input lost or duplicated after release.
- Collision: the stage-2 read of 0x55 coincides with tbl_we to 0x55 with data 0x0E -> out_data 0x0E.
- Counter: force CNT_W=4 and complete 20 lookups -> lookup_cnt=15. Assert rst_n low mid-stream -> out_valid=0 and lookup_cnt=0 immediately.
- SYMM_EN: table[5]=0x50, input +5 -> 0x50. Input -5 -> 0x2F. Input -64 with table[63]=0x7F -> 0x00.
